// File: rtl/cond_pkg.sv
// Shared definitions for the Execute-stage condition unit: condition codes,
// flag register bit positions and FlagWrite group indices.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int unsigned FLAGS_W = 5;
    localparam int unsigned FLAG_N  = 4;
    localparam int unsigned FLAG_Z  = 3;
    localparam int unsigned FLAG_C  = 2;
    localparam int unsigned FLAG_V  = 1;
    localparam int unsigned FLAG_Q  = 0;

    localparam int unsigned FW_NZ = 1;
    localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition-field evaluator against {N,Z,C,V}.
module cond_check (
    input  logic [3:0] CondE,
    input  logic [3:0] NZCV,
    output logic       CondEx
);
    import cond_pkg::*;

    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = NZCV;
        CondEx = 1'b0;
        case (cond_e'(CondE))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition/flag unit: flag register, condition gating, sticky Q.
// Optional COND_SATURATION_EN enables Q tracking and the saturation counter.
module cond_unit #(
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ValidE,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic [3:0]           CondE,
    input  logic [1:0]           FlagWriteE,
    input  logic                 QOpE,
    input  logic [4:0]           ALUFlags,
    input  logic                 QClear,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 PCSE,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 PCSrc,
    output logic                 CondEx,
    output logic [4:0]           Flags,
    output logic [SAT_CNT_W-1:0] SatCount
);
    import cond_pkg::*;

    logic [FLAGS_W-1:0] flags_q, flags_d;
    logic               cond_ex;
    logic               go;
    logic               issue;

    cond_check u_cond_check (
        .CondE  (CondE),
        .NZCV   (flags_q[FLAG_N:FLAG_V]),
        .CondEx (cond_ex)
    );

    // Stall does not gate the control outputs; the downstream register holds them.
    always_comb begin
        issue    = ValidE & cond_ex & ~FlushE;
        go       = issue & ~StallE;
        CondEx   = cond_ex;
        RegWrite = RegWriteE & issue;
        MemWrite = MemWriteE & issue;
        PCSrc    = PCSE & issue;
    end

`ifdef COND_SATURATION_EN
    logic                 q_set;
    logic [SAT_CNT_W-1:0] sat_q, sat_d;

    // Set beats clear for both Q and the counter; a same-cycle clear+set yields 1.
    always_comb begin
        q_set   = go & QOpE & ALUFlags[FLAG_Q];
        flags_d = flags_q;
        sat_d   = sat_q;
        if (go & FlagWriteE[FW_NZ]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (go & FlagWriteE[FW_CV]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        if (QClear) begin
            flags_d[FLAG_Q] = 1'b0;
            sat_d           = '0;
        end
        if (q_set) begin
            flags_d[FLAG_Q] = 1'b1;
            if (QClear) begin
                sat_d = SAT_CNT_W'(1);
            end else if (sat_q != '1) begin
                sat_d = sat_q + SAT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign SatCount = sat_q;
`else
    logic unused_sat_inputs;

    always_comb begin
        flags_d = flags_q;
        if (go & FlagWriteE[FW_NZ]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (go & FlagWriteE[FW_CV]) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        flags_d[FLAG_Q] = 1'b0;
    end

    assign unused_sat_inputs = ^{QOpE, ALUFlags[FLAG_Q], QClear};
    assign SatCount          = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign Flags = flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: vector table for condition decode and gating,
// hand sequences for stall/flush, sticky Q, counter saturation and async reset.
module tb_cond_unit;
    import cond_pkg::*;

`ifdef COND_SATURATION_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk, reset;
    logic        ValidE, StallE, FlushE, QOpE, QClear;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic [4:0]  ALUFlags;
    logic        RegWriteE, MemWriteE, PCSE;
    logic        RegWrite, MemWrite, PCSrc, CondEx;
    logic [4:0]  Flags;
    logic [15:0] SatCount;
    logic        s_RegWrite, s_MemWrite, s_PCSrc, s_CondEx;
    logic [4:0]  s_Flags;
    logic [1:0]  s_SatCount;

    int tests = 0;
    int failed = 0;

    cond_unit #(.SAT_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .QOpE(QOpE), .ALUFlags(ALUFlags),
        .QClear(QClear), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSE(PCSE),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc), .CondEx(CondEx),
        .Flags(Flags), .SatCount(SatCount)
    );

    cond_unit #(.SAT_CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .ValidE(ValidE), .StallE(StallE), .FlushE(FlushE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .QOpE(QOpE), .ALUFlags(ALUFlags),
        .QClear(QClear), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSE(PCSE),
        .RegWrite(s_RegWrite), .MemWrite(s_MemWrite), .PCSrc(s_PCSrc), .CondEx(s_CondEx),
        .Flags(s_Flags), .SatCount(s_SatCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cond;
        logic       valid, stall, flush;
        logic [1:0] fw;
        logic [4:0] alu;
        logic       rw, mw, pc;
        logic       e_cex, e_rw, e_mw, e_pc;
        logic [4:0] e_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] cond, logic valid, logic stall, logic flush,
                                logic [1:0] fw, logic [4:0] alu, logic rw, logic mw,
                                logic pc, logic e_cex, logic e_rw, logic e_mw,
                                logic e_pc, logic [4:0] e_flags);
        vec_t r;
        r.cond = cond; r.valid = valid; r.stall = stall; r.flush = flush;
        r.fw = fw; r.alu = alu; r.rw = rw; r.mw = mw; r.pc = pc;
        r.e_cex = e_cex; r.e_rw = e_rw; r.e_mw = e_mw; r.e_pc = e_pc;
        r.e_flags = e_flags;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ValidE = 1'b0; StallE = 1'b0; FlushE = 1'b0; CondE = 4'b1110;
        FlagWriteE = 2'b00; QOpE = 1'b0; ALUFlags = 5'b0; QClear = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; PCSE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic q_event(input logic clr);
        idle();
        ValidE = 1'b1; CondE = COND_AL; QOpE = 1'b1; ALUFlags = 5'b00001; QClear = clr;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        ValidE = 1'b1;
        CondE = COND_AL;
        #2;
        chk("reset_condex_al", {31'b0, CondEx}, 32'd1);
        chk("reset_flags", {27'b0, Flags}, 32'd0);
        chk("reset_satcount", {16'b0, SatCount}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle();

        // Flags before each row follow from the previous row's e_flags.
        vecs.push_back(mk(COND_EQ, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(COND_AL, 1, 0, 0, 2'b11, 5'b01100, 1, 1, 1, 1, 1, 1, 1, 5'b01100));
        vecs.push_back(mk(COND_EQ, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 1, 1, 0, 0, 5'b01100));
        vecs.push_back(mk(COND_NE, 1, 0, 0, 2'b11, 5'b10000, 0, 1, 0, 0, 0, 0, 0, 5'b01100));
        vecs.push_back(mk(COND_CS, 1, 0, 0, 2'b01, 5'b00000, 0, 0, 1, 1, 0, 0, 1, 5'b01000));
        vecs.push_back(mk(COND_CC, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 1, 1, 0, 0, 5'b01000));
        vecs.push_back(mk(COND_HI, 1, 0, 0, 2'b11, 5'b10000, 1, 0, 0, 0, 0, 0, 0, 5'b01000));
        vecs.push_back(mk(COND_LS, 1, 0, 0, 2'b10, 5'b10000, 1, 0, 0, 1, 1, 0, 0, 5'b10000));
        vecs.push_back(mk(COND_MI, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 1, 1, 0, 0, 5'b10000));
        vecs.push_back(mk(COND_GE, 1, 0, 0, 2'b01, 5'b00010, 1, 0, 0, 0, 0, 0, 0, 5'b10000));
        vecs.push_back(mk(COND_LT, 1, 0, 0, 2'b01, 5'b00010, 0, 1, 0, 1, 0, 1, 0, 5'b10010));
        vecs.push_back(mk(COND_GE, 1, 0, 0, 2'b00, 5'b00000, 0, 0, 1, 1, 0, 0, 1, 5'b10010));
        vecs.push_back(mk(COND_GT, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 1, 1, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_LE, 1, 0, 0, 2'b11, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_PL, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_VS, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 1, 1, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_VC, 1, 0, 0, 2'b00, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_NV, 1, 0, 0, 2'b11, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_AL, 0, 0, 0, 2'b11, 5'b00000, 1, 0, 0, 1, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_AL, 1, 1, 0, 2'b11, 5'b00000, 1, 1, 0, 1, 1, 1, 0, 5'b10010));
        vecs.push_back(mk(COND_AL, 1, 0, 1, 2'b11, 5'b00000, 1, 0, 1, 1, 0, 0, 0, 5'b10010));
        vecs.push_back(mk(COND_AL, 1, 0, 0, 2'b11, 5'b00000, 0, 0, 0, 1, 0, 0, 0, 5'b00000));

        foreach (vecs[i]) begin
            idle();
            CondE = vecs[i].cond; ValidE = vecs[i].valid; StallE = vecs[i].stall;
            FlushE = vecs[i].flush; FlagWriteE = vecs[i].fw; ALUFlags = vecs[i].alu;
            RegWriteE = vecs[i].rw; MemWriteE = vecs[i].mw; PCSE = vecs[i].pc;
            #1;
            chk($sformatf("v%0d_condex", i), {31'b0, CondEx}, {31'b0, vecs[i].e_cex});
            chk($sformatf("v%0d_regwrite", i), {31'b0, RegWrite}, {31'b0, vecs[i].e_rw});
            chk($sformatf("v%0d_memwrite", i), {31'b0, MemWrite}, {31'b0, vecs[i].e_mw});
            chk($sformatf("v%0d_pcsrc", i), {31'b0, PCSrc}, {31'b0, vecs[i].e_pc});
            tick();
            chk($sformatf("v%0d_flags", i), {27'b0, Flags}, {27'b0, vecs[i].e_flags});
            chk($sformatf("v%0d_sat", i), {16'b0, SatCount}, 32'd0);
        end

        // Stall for three cycles, then release: N updates exactly once.
        idle();
        ValidE = 1'b1; CondE = COND_AL; FlagWriteE = 2'b10; ALUFlags = 5'b10000;
        RegWriteE = 1'b1; StallE = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_regwrite", k), {31'b0, RegWrite}, 32'd1);
            tick();
            chk($sformatf("stall%0d_flags", k), {27'b0, Flags}, 32'd0);
        end
        StallE = 1'b0;
        tick();
        chk("stall_release_flags", {27'b0, Flags}, 32'b10000);

        idle();
        ValidE = 1'b1; CondE = COND_AL; FlagWriteE = 2'b10; ALUFlags = 5'b00000;
        RegWriteE = 1'b1; FlushE = 1'b1;
        #1;
        chk("flush_regwrite", {31'b0, RegWrite}, 32'd0);
        tick();
        chk("flush_flags", {27'b0, Flags}, 32'b10000);

        idle();
        ValidE = 1'b1; CondE = COND_AL; FlagWriteE = 2'b11;
        tick();
        chk("clear_nzcv", {27'b0, Flags}, 32'd0);

        // Sticky Q and saturation counter.
        for (int k = 0; k < 3; k++) q_event(1'b0);
        chk("q3_flags", {27'b0, Flags}, SAT_EN ? 32'b00001 : 32'd0);
        chk("q3_sat", {16'b0, SatCount}, SAT_EN ? 32'd3 : 32'd0);
        chk("q3_sat_small", {30'b0, s_SatCount}, SAT_EN ? 32'd3 : 32'd0);
        q_event(1'b1);
        chk("qclr_set_flags", {27'b0, Flags}, SAT_EN ? 32'b00001 : 32'd0);
        chk("qclr_set_sat", {16'b0, SatCount}, SAT_EN ? 32'd1 : 32'd0);
        idle();
        QClear = 1'b1;
        tick();
        chk("qclr_flags", {27'b0, Flags}, 32'd0);
        chk("qclr_sat", {16'b0, SatCount}, 32'd0);

        q_event(1'b0);
        chk("q1_sat", {16'b0, SatCount}, SAT_EN ? 32'd1 : 32'd0);
        idle();
        ValidE = 1'b1; CondE = COND_AL; QOpE = 1'b1; ALUFlags = 5'b00001;
        QClear = 1'b1; StallE = 1'b1; FlushE = 1'b1;
        tick();
        chk("qclr_stall_flags", {27'b0, Flags}, 32'd0);
        chk("qclr_stall_sat", {16'b0, SatCount}, 32'd0);

        idle();
        ValidE = 1'b1; CondE = COND_EQ; QOpE = 1'b1; ALUFlags = 5'b00001;
        tick();
        chk("q_condfail_flags", {27'b0, Flags}, 32'd0);
        chk("q_condfail_sat", {16'b0, SatCount}, 32'd0);

        for (int k = 0; k < 5; k++) q_event(1'b0);
        chk("q5_sat", {16'b0, SatCount}, SAT_EN ? 32'd5 : 32'd0);
        chk("q5_sat_small", {30'b0, s_SatCount}, SAT_EN ? 32'd3 : 32'd0);
        chk("q5_flags_small", {27'b0, s_Flags}, SAT_EN ? 32'b00001 : 32'd0);

        // Async reset in mid-cycle drops the pending flag update.
        idle();
        ValidE = 1'b1; CondE = COND_AL; FlagWriteE = 2'b11; ALUFlags = 5'b01100;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_flags", {27'b0, Flags}, 32'd0);
        chk("async_reset_sat", {16'b0, SatCount}, 32'd0);
        tick();
        chk("reset_hold_flags", {27'b0, Flags}, 32'd0);
        reset = 1'b0;
        tick();
        chk("post_reset_update", {27'b0, Flags}, 32'b01100);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
